// File: rtl/reloj_control.sv
// Timekeeping sequencer: seconds/minutes/hours counters with cascaded carries
// from a 1 Hz tick, plus a button-driven edit mode. All outputs are registered.
module reloj_control #(
  parameter int unsigned S_MAX = 59,
  parameter int unsigned M_MAX = 59,
  parameter int unsigned H_MAX = 23
) (
  input  logic       clk,
  input  logic       reset_clk,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [5:0] segundos,
  output logic [5:0] minutos,
  output logic [4:0] horas,
  output logic [1:0] edit_field,
  output logic       running,
  output logic       day_pulse
);

  localparam logic [5:0] S_TOP = S_MAX[5:0];
  localparam logic [5:0] M_TOP = M_MAX[5:0];
  localparam logic [4:0] H_TOP = H_MAX[4:0];

  // State encoding doubles as the edit_field output value.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       day_q, day_d;
  logic       run_q, run_d;

  logic s_wrap, m_wrap, h_wrap;
  logic adj_up, adj_dn;

  // ">=" so an out-of-range value still wraps to 0 on the next increment.
  assign s_wrap = (sec_q >= S_TOP);
  assign m_wrap = (min_q >= M_TOP);
  assign h_wrap = (hr_q  >= H_TOP);

  // Simultaneous up+down cancel out.
  assign adj_up = btn_up & ~btn_down;
  assign adj_dn = btn_down & ~btn_up;

  always_ff @(posedge clk) begin
    if (reset_clk) begin
      state_q <= RUN;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      day_q   <= 1'b0;
      run_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      day_q   <= day_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    day_d   = 1'b0;

    if (state_q == RUN) begin
      // Tick is applied even on the edge that enters edit mode.
      if (tick_1hz) begin
        sec_d = s_wrap ? '0 : sec_q + 6'd1;
        if (s_wrap) begin
          min_d = m_wrap ? '0 : min_q + 6'd1;
          if (m_wrap) begin
            hr_d  = h_wrap ? '0 : hr_q + 5'd1;
            day_d = h_wrap;
          end
        end
      end
      if (btn_mode) state_d = SET_H;
    end else if (btn_mode) begin
      state_d = RUN;
    end else if (btn_next) begin
      case (state_q)
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = SET_H;
      endcase
    end else begin
      case (state_q)
        SET_H: begin
          if (adj_up) hr_d = h_wrap ? '0 : hr_q + 5'd1;
          if (adj_dn) hr_d = (hr_q == '0) ? H_TOP : hr_q - 5'd1;
        end
        SET_M: begin
          if (adj_up) min_d = m_wrap ? '0 : min_q + 6'd1;
          if (adj_dn) min_d = (min_q == '0) ? M_TOP : min_q - 6'd1;
        end
        default: begin
          if (adj_up) sec_d = s_wrap ? '0 : sec_q + 6'd1;
          if (adj_dn) sec_d = (sec_q == '0) ? S_TOP : sec_q - 6'd1;
        end
      endcase
    end

    run_d = (state_d == RUN);
  end

  assign segundos   = sec_q;
  assign minutos    = min_q;
  assign horas      = hr_q;
  assign edit_field = state_q;
  assign running    = run_q;
  assign day_pulse  = day_q;

endmodule

// File: doc/reloj_control.md
Name: reloj_control

Overview:
- Timekeeping sequencer for the clock datapath: owns the seconds (0–59), minutes (0–59) and hours (0–23) counters.
- Advances them from a 1 Hz tick with cascaded carries.
- Provides a user edit mode, driven by pre-debounced button pulses, to set each field.
- Sits between the button/debounce logic and the display formatter; all outputs are registered.

Parameters:
- S_MAX, 59, terminal value of the seconds field (≤63).
- M_MAX, 59, terminal value of the minutes field (≤63).
- H_MAX, 23, terminal value of the hours field (≤31).

Ports:
- clk  input  1  system clock
- reset_clk  input  1  synchronous, active-high reset, sampled on posedge clk
- tick_1hz  input  1  one-cycle pulse, once per second
- btn_mode  input  1  one-cycle pulse: enter/leave edit mode
- btn_next  input  1  one-cycle pulse: select next field in edit mode
- btn_up  input  1  one-cycle pulse: increment selected field
- btn_down  input  1  one-cycle pulse: decrement selected field
- segundos  output  6  current seconds
- minutos  output  6  current minutes
- horas  output  5  current hours
- edit_field  output  2  0=none (RUN), 1=hours, 2=minutes, 3=seconds
- running  output  1  1 when in RUN state
- day_pulse  output  1  one-cycle pulse on 23:59:59→00:00:00 rollover

Behaviour:
- Clock and reset:
  - Single clock domain; clk and reset_clk as named above.
  - Reset is synchronous and active-high; it has priority over every other input.
  - Reset values: segundos=0, minutos=0, horas=0, state=RUN, edit_field=0, running=1, day_pulse=0.
  - Reset asserted mid-edit returns to RUN at 00:00:00 on the same edge.
- FSM states: RUN, SET_H, SET_M, SET_S. Current state is encoded directly on edit_field (0/1/2/3); running = (state==RUN).
- Per-edge input priority: reset_clk > btn_mode > btn_next > btn_up/btn_down. Only one button action is taken per edge.
- State transitions:
  - RUN + btn_mode → SET_H.
  - Any SET_x + btn_mode → RUN.
  - SET_H + btn_next → SET_M; SET_M + btn_next → SET_S; SET_S + btn_next → SET_H.
  - btn_next in RUN is ignored.
  - Field values are unchanged by any state transition.
- RUN counting:
  - Counting occurs on an edge where the current state is RUN and tick_1hz=1. This includes the edge on which btn_mode moves the FSM to SET_H: that tick is still applied.
  - Seconds increment; at S_MAX they wrap to 0 and carry into minutes.
  - Minutes increment on carry; at M_MAX they wrap to 0 and carry into hours.
  - Hours increment on carry; at H_MAX they wrap to 0.
  - All three fields update on the same edge, with no extra latency.
  - day_pulse=1 for exactly the cycle following the edge on which all three fields wrapped; otherwise 0.
- Edit states:
  - tick_1hz is ignored; time is frozen.
  - btn_up increments the selected field, wrapping MAX→0.
  - btn_down decrements the selected field, wrapping 0→MAX.
  - btn_up and btn_down together: no change.
  - Up/down never carry into neighbouring fields, and day_pulse never asserts in edit.
  - btn_up/btn_down in RUN are ignored.
- Arithmetic:
  - Unsigned, at the full field width.
  - Comparisons are against the parameter values.
  - A value above MAX (not reachable in normal operation) wraps to 0 on the next increment.
- Latency: every output reflects its input event one clk edge after it is sampled.

Test Plan:
- Reset: run a few ticks, then pulse reset_clk while in SET_M → next cycle 00:00:00, edit_field=0, running=1, day_pulse=0.
- Cascade: time 00:00:58, two tick_1hz pulses → 00:00:59, then 00:01:00; a further check from 00:59:59 with one tick → 01:00:00.
- Day rollover: time 23:59:59, one tick → 00:00:00 with day_pulse high for exactly one cycle. Ticks on non-consecutive cycles must not hold day_pulse high.
- Edit navigation: btn_mode → edit_field=1; btn_up ×3 from horas=22 → 23, 0, 1. btn_next → edit_field=2; btn_down from minutos=0 → 59, horas unchanged. btn_next ×2 → edit_field=1; btn_mode → RUN, values preserved.
- Freeze and simultaneity:
  - In SET_S, 5 tick_1hz pulses → segundos unchanged.
  - btn_up+btn_down on the same cycle → no change.
  - btn_mode+btn_up on the same cycle in SET_H → state RUN, horas unchanged.
- Tick on mode entry: at 00:00:10 assert btn_mode and tick_1hz on the same edge → state SET_H, segundos=11.
